// File: rtl/gmii_mux_cpu_regs_pkg.sv
// gmii_mux_cpu_regs_pkg: register map, field widths, reset values
// and AXI response codes shared by the GMII mux CPU register block.
package gmii_mux_cpu_regs_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned RESP_W = 2;

    localparam int unsigned OFF_ID      = 'h0;
    localparam int unsigned OFF_VERSION = 'h4;
    localparam int unsigned OFF_SELECT  = 'h8;
    localparam int unsigned OFF_SCRATCH = 'hC;

    localparam logic [DATA_W-1:0] SELECT_RST  = 32'h0000_0001;
    localparam logic [DATA_W-1:0] SCRATCH_RST = 32'h0000_0000;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_ID,
        REG_VERSION,
        REG_SELECT,
        REG_SCRATCH,
        REG_NONE
    } reg_sel_e;

    function automatic logic [DATA_W-1:0] apply_strb(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/gmii_mux_cpu_regs_axi_if.sv
// gmii_mux_cpu_regs_axi_if: AXI-Lite slave handshakes for the register block.
// Ports: AXI write/read channels (*_i/*_o); wr_en_o/rd_en_o strobes with
// address/data toward the register file, wr_resp_i/rd_data_i/rd_resp_i back.
module gmii_mux_cpu_regs_axi_if
    import gmii_mux_cpu_regs_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AW-1:0]     awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    output logic [RESP_W-1:0] bresp_o,
    output logic              bvalid_o,
    input  logic              bready_i,
    input  logic [AW-1:0]     araddr_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [RESP_W-1:0] rresp_o,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic              wr_en_o,
    output logic [AW-1:0]     wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [STRB_W-1:0] wr_strb_o,
    input  logic [RESP_W-1:0] wr_resp_i,
    output logic              rd_en_o,
    output logic [AW-1:0]     rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic [RESP_W-1:0] rd_resp_i
);

    logic              awready_q, awready_d;
    logic              bvalid_q,  bvalid_d;
    logic [RESP_W-1:0] bresp_q,   bresp_d;
    logic              arready_q, arready_d;
    logic              rvalid_q,  rvalid_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic [RESP_W-1:0] rresp_q,   rresp_d;

    // Address and data are accepted together; the ready pulse is only
    // raised while both valids are held, so ready implies a handshake.
    assign wr_en_o   = awready_q & awvalid_i & wvalid_i;
    assign wr_addr_o = awaddr_i;
    assign wr_data_o = wdata_i;
    assign wr_strb_o = wstrb_i;

    assign rd_en_o   = arready_q & arvalid_i;
    assign rd_addr_o = araddr_i;

    always_comb begin
        awready_d = awvalid_i & wvalid_i & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (wr_en_o) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp_i;
        end else if (bready_i) begin
            bvalid_d = 1'b0;
        end
    end

    always_comb begin
        arready_d = arvalid_i & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (rd_en_o) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_i;
            rresp_d  = rd_resp_i;
        end else if (rready_i) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = awready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

endmodule

// File: rtl/gmii_mux_cpu_regs.sv
// gmii_mux_cpu_regs: AXI-Lite registers for the GMII mux (ID, VERSION, SELECT).
// Ports: S_AXI_* slave bus, id_reg/version_reg RO inputs, select_reg output.
// Define GMII_MUX_CPU_REGS_SCRATCH_EN to add a RW scratch register at 0xC.
module gmii_mux_cpu_regs
    import gmii_mux_cpu_regs_pkg::*;
#(
    parameter logic [31:0] C_BASE_ADDRESS     = 32'h0,
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 12
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [31:0]                     id_reg,
    input  logic [31:0]                     version_reg,
    output logic [31:0]                     select_reg
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] BASE = AW'(C_BASE_ADDRESS);

    localparam logic [AW-3:0] W_ID      = (AW-2)'(OFF_ID >> 2);
    localparam logic [AW-3:0] W_VERSION = (AW-2)'(OFF_VERSION >> 2);
    localparam logic [AW-3:0] W_SELECT  = (AW-2)'(OFF_SELECT >> 2);
    localparam logic [AW-3:0] W_SCRATCH = (AW-2)'(OFF_SCRATCH >> 2);

    logic              wr_en, rd_en;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [AW-1:0]     wr_off, rd_off;
    logic [DATA_W-1:0] wr_data, rd_data;
    logic [STRB_W-1:0] wr_strb;
    logic [RESP_W-1:0] wr_resp, rd_resp;
    reg_sel_e          wr_sel, rd_sel;

    logic [DATA_W-1:0] select_q, select_d;

    function automatic reg_sel_e decode(input logic [AW-3:0] w);
        reg_sel_e s;
        s = REG_NONE;
        if (w == W_ID)      s = REG_ID;
        if (w == W_VERSION) s = REG_VERSION;
        if (w == W_SELECT)  s = REG_SELECT;
`ifdef GMII_MUX_CPU_REGS_SCRATCH_EN
        if (w == W_SCRATCH) s = REG_SCRATCH;
`else
        if (w == W_SCRATCH) s = REG_NONE;
`endif
        return s;
    endfunction

    gmii_mux_cpu_regs_axi_if #(
        .AW (AW)
    ) u_axi_if (
        .clk_i     (S_AXI_ACLK),
        .rst_i     (S_AXI_ARESET),
        .awaddr_i  (S_AXI_AWADDR),
        .awvalid_i (S_AXI_AWVALID),
        .awready_o (S_AXI_AWREADY),
        .wdata_i   (S_AXI_WDATA),
        .wstrb_i   (S_AXI_WSTRB),
        .wvalid_i  (S_AXI_WVALID),
        .wready_o  (S_AXI_WREADY),
        .bresp_o   (S_AXI_BRESP),
        .bvalid_o  (S_AXI_BVALID),
        .bready_i  (S_AXI_BREADY),
        .araddr_i  (S_AXI_ARADDR),
        .arvalid_i (S_AXI_ARVALID),
        .arready_o (S_AXI_ARREADY),
        .rdata_o   (S_AXI_RDATA),
        .rresp_o   (S_AXI_RRESP),
        .rvalid_o  (S_AXI_RVALID),
        .rready_i  (S_AXI_RREADY),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .wr_resp_i (wr_resp),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data),
        .rd_resp_i (rd_resp)
    );

    // Byte lanes within a word are ignored by the decode.
    assign wr_off = wr_addr - BASE;
    assign rd_off = rd_addr - BASE;
    assign wr_sel = decode(wr_off[AW-1:2]);
    assign rd_sel = decode(rd_off[AW-1:2]);

    logic unused_lanes;
    assign unused_lanes = ^{wr_off[1:0], rd_off[1:0]};

    assign wr_resp = (wr_sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;

`ifdef GMII_MUX_CPU_REGS_SCRATCH_EN
    logic [DATA_W-1:0] scratch_q, scratch_d;

    always_comb begin
        scratch_d = scratch_q;
        if (wr_en && wr_sel == REG_SCRATCH)
            scratch_d = apply_strb(scratch_q, wr_data, wr_strb);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) scratch_q <= SCRATCH_RST;
        else              scratch_q <= scratch_d;
    end
`else
    logic unused_rd_en;
    assign unused_rd_en = rd_en;
`endif

    always_comb begin
        select_d = select_q;
        if (wr_en && wr_sel == REG_SELECT)
            select_d = apply_strb(select_q, wr_data, wr_strb);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) select_q <= SELECT_RST;
        else              select_q <= select_d;
    end

    // Read data is captured by the interface on the same edge a write
    // commits, so a colliding read of SELECT sees the old value.
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (rd_sel)
            REG_ID:      rd_data = id_reg;
            REG_VERSION: rd_data = version_reg;
            REG_SELECT:  rd_data = select_q;
`ifdef GMII_MUX_CPU_REGS_SCRATCH_EN
            REG_SCRATCH: rd_data = rd_en ? scratch_q : scratch_q;
`endif
            default:     rd_resp = RESP_SLVERR;
        endcase
    end

    assign select_reg = select_q;

endmodule

// File: tb/tb_gmii_mux_cpu_regs.sv
// tb_gmii_mux_cpu_regs: directed self-checking bench for gmii_mux_cpu_regs.
// Honours GMII_MUX_CPU_REGS_SCRATCH_EN for the 0xC scratch register.
module tb_gmii_mux_cpu_regs;

    logic        clk = 1'b0;
    logic        areset;
    logic [11:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [11:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] id_reg;
    logic [31:0] version_reg;
    logic [31:0] select_reg;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    gmii_mux_cpu_regs dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (areset),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .id_reg        (id_reg),
        .version_reg   (version_reg),
        .select_reg    (select_reg)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues a write, returns BRESP and select_reg one cycle after the
    // handshake. With hold > 0 BREADY stays low for hold cycles while a
    // second write is offered, which must not be accepted.
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int hold,
                             output logic [1:0] r, output logic [31:0] sel);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_seen", {31'b0, wready}, 32'h1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_rise", {31'b0, bvalid}, 32'h1);
        sel = select_reg;
        r = bresp;
        if (hold > 0) begin
            awaddr = 12'h008; wdata = 32'h1234_5678; wstrb = 4'hF;
            awvalid = 1'b1; wvalid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("bvalid_hold", {31'b0, bvalid}, 32'h1);
                check("awready_low", {31'b0, awready}, 32'h0);
            end
            awvalid = 1'b0; wvalid = 1'b0;
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_fall", {31'b0, bvalid}, 32'h0);
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d,
                            output logic [1:0] r);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arready_seen", {31'b0, arready}, 32'h1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_rise", {31'b0, rvalid}, 32'h1);
        d = rdata;
        r = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        logic [31:0] s;
        int          n;

        areset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        id_reg = 32'h0000_DA01; version_reg = 32'h0001_0000;

        repeat (3) @(negedge clk);
        check("rst_awready", {31'b0, awready}, 32'h0);
        check("rst_wready",  {31'b0, wready},  32'h0);
        check("rst_bvalid",  {31'b0, bvalid},  32'h0);
        check("rst_arready", {31'b0, arready}, 32'h0);
        check("rst_rvalid",  {31'b0, rvalid},  32'h0);
        check("rst_rdata",   rdata, 32'h0);
        check("rst_resp",    {28'b0, bresp, rresp}, 32'h0);
        check("rst_select",  select_reg, 32'h1);
        areset = 1'b0;

        axi_read(12'h008, d, r);
        check("rd_sel_rst", d, 32'h1);
        check("rd_sel_rst_resp", {30'b0, r}, 32'h0);

        axi_read(12'h000, d, r);
        check("rd_id", d, 32'h0000_DA01);
        check("rd_id_resp", {30'b0, r}, 32'h0);
        axi_read(12'h004, d, r);
        check("rd_version", d, 32'h0001_0000);

        axi_write(12'h008, 32'h0, 4'hF, 0, r, s);
        check("wr_sel0_resp", {30'b0, r}, 32'h0);
        check("wr_sel0_next", s, 32'h0);
        axi_read(12'h008, d, r);
        check("rd_sel0", d, 32'h0);

        axi_write(12'h008, 32'hFFFF_FFFF, 4'h1, 0, r, s);
        check("wr_strb1", s, 32'h0000_00FF);

        axi_write(12'h000, 32'h5, 4'hF, 0, r, s);
        check("wr_id_resp", {30'b0, r}, 32'h0);
        check("wr_id_sel", s, 32'h0000_00FF);
        axi_read(12'h000, d, r);
        check("rd_id_after", d, 32'h0000_DA01);

        axi_read(12'h010, d, r);
        check("rd_unmap_data", d, 32'h0);
        check("rd_unmap_resp", {30'b0, r}, 32'h2);
        axi_write(12'h010, 32'h9, 4'hF, 0, r, s);
        check("wr_unmap_resp", {30'b0, r}, 32'h2);
        check("wr_unmap_sel", s, 32'h0000_00FF);

        axi_write(12'h008, 32'h3, 4'hF, 5, r, s);
        check("hold_resp", {30'b0, r}, 32'h0);
        check("hold_sel_after", select_reg, 32'h3);

        axi_read(12'h009, d, r);
        check("rd_unaligned", d, 32'h3);

        axi_write(12'h008, 32'hAABB_CCDD, 4'hA, 0, r, s);
        check("wr_strbA", s, 32'hAA00_CC03);

`ifdef GMII_MUX_CPU_REGS_SCRATCH_EN
        axi_read(12'h00C, d, r);
        check("rd_scr_rst", d, 32'h0);
        axi_write(12'h00C, 32'hA5A5_A5A5, 4'hF, 0, r, s);
        check("wr_scr_resp", {30'b0, r}, 32'h0);
        axi_read(12'h00C, d, r);
        check("rd_scr", d, 32'hA5A5_A5A5);
        check("rd_scr_resp", {30'b0, r}, 32'h0);
`else
        axi_write(12'h00C, 32'hA5A5_A5A5, 4'hF, 0, r, s);
        check("wr_scr_resp", {30'b0, r}, 32'h2);
        axi_read(12'h00C, d, r);
        check("rd_scr", d, 32'h0);
        check("rd_scr_resp", {30'b0, r}, 32'h2);
`endif

        // Read and write of SELECT accepted on the same edge.
        @(negedge clk);
        awaddr = 12'h008; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; araddr = 12'h008; arvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("coll_awready", {31'b0, awready}, 32'h1);
        check("coll_arready", {31'b0, arready}, 32'h1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_rvalid", {31'b0, rvalid}, 32'h1);
        check("coll_rdata_old", rdata, 32'hAA00_CC03);
        check("coll_sel_new", select_reg, 32'h77);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;

        // Reset while a read response is pending.
        @(negedge clk);
        araddr = 12'h004; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        check("mid_rvalid", {31'b0, rvalid}, 32'h1);
        areset = 1'b1;
        @(negedge clk);
        check("mid_rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_sel", select_reg, 32'h1);
        areset = 1'b0;
        axi_read(12'h008, d, r);
        check("post_rst_sel", d, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
